// File: rtl/iotdf_param.sv
// -----------------------------------------------------------------------------
// iotdf_param : parametrised IoT data filter
//
// Packs an IN_W-bit beat stream (MSB beat first) into DW = IN_W*N_BYTES bit
// unsigned items, groups items into rounds of ROUND_LEN and applies one of
// seven filter / reduce functions per round.
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   rst_n    in   synchronous active-low reset
//   in_en    in   input beat valid (accepted only while busy = 0)
//   iot_in   in   IN_W-bit input beat, first beat of an item is its MSB
//   fn_sel   in   function: 1 MAX, 2 MIN, 3 AVG, 4 EXT, 5 EXC, 6 PMAX,
//                 7 PMIN, 0 none; latched on the first beat of a round
//   thr_lo   in   lower threshold for EXT/EXC, latched with fn_sel
//   thr_hi   in   upper threshold for EXT/EXC, latched with fn_sel
//   busy     out  high for the single round-end evaluation cycle
//   valid    out  single-cycle result strobe
//   iot_out  out  result, holds its last value while valid = 0
//
// ROUND_LEN must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module iotdf_param #(
    parameter int IN_W      = 8,
    parameter int N_BYTES   = 16,
    parameter int ROUND_LEN = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_en,
    input  logic [IN_W-1:0]         iot_in,
    input  logic [2:0]              fn_sel,
    input  logic [IN_W*N_BYTES-1:0] thr_lo,
    input  logic [IN_W*N_BYTES-1:0] thr_hi,
    output logic                    busy,
    output logic                    valid,
    output logic [IN_W*N_BYTES-1:0] iot_out
);

    localparam int DW    = IN_W * N_BYTES;
    localparam int LOG2R = $clog2(ROUND_LEN);
    // The sum of ROUND_LEN items needs LOG2R extra bits to never overflow.
    localparam int SW    = DW + LOG2R;
    localparam int BCW   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int ICW   = LOG2R;

    localparam logic [BCW-1:0] LAST_BEAT = BCW'(N_BYTES - 1);
    localparam logic [ICW-1:0] LAST_ITEM = ICW'(ROUND_LEN - 1);

    localparam logic [2:0] FN_NONE = 3'd0;
    localparam logic [2:0] FN_MAX  = 3'd1;
    localparam logic [2:0] FN_MIN  = 3'd2;
    localparam logic [2:0] FN_AVG  = 3'd3;
    localparam logic [2:0] FN_EXT  = 3'd4;
    localparam logic [2:0] FN_EXC  = 3'd5;
    localparam logic [2:0] FN_PMAX = 3'd6;
    localparam logic [2:0] FN_PMIN = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EVAL = 2'd2
    } state_t;

    state_t          state_q, state_d;

    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ICW-1:0]  item_cnt_q, item_cnt_d;
    logic [DW-1:0]   item_q, item_d;
    logic [2:0]      fn_q, fn_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   max_q, max_d;
    logic [DW-1:0]   min_q, min_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [DW-1:0]   peak_q, peak_d;
    logic            peak_set_q, peak_set_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   out_q, out_d;

    logic            accept;
    logic            round_start;
    logic            item_done;
    logic            first_item;
    logic            last_item;
    logic            round_done;
    logic            round_fn;
    logic [2:0]      fn_eff;
    logic [DW-1:0]   lo_eff;
    logic [DW-1:0]   hi_eff;
    logic [DW-1:0]   item_new;
    logic [DW-1:0]   rmax;
    logic [DW-1:0]   rmin;
    logic [SW-1:0]   rsum;
    logic            in_window;
    logic            out_window;

    // ------------------------------------------------------------------
    // Beat acceptance and item assembly
    // ------------------------------------------------------------------
    assign accept      = in_en && (state_q != S_EVAL);
    assign round_start = accept && (beat_cnt_q == '0) && (item_cnt_q == '0);
    assign item_done   = accept && (beat_cnt_q == LAST_BEAT);
    assign first_item  = (item_cnt_q == '0);
    assign last_item   = (item_cnt_q == LAST_ITEM);
    assign round_done  = item_done && last_item;

    // On the first beat of a round the live inputs are the values being
    // latched, so they already govern that beat.
    assign fn_eff = round_start ? fn_sel : fn_q;
    assign lo_eff = round_start ? thr_lo : lo_q;
    assign hi_eff = round_start ? thr_hi : hi_q;

    // MSB beat arrives first, so each new beat shifts in at the bottom.
    // After N_BYTES shifts every stale bit of the previous item is gone.
    assign item_new = (item_q << IN_W) | DW'(iot_in);

    // Round statistics including the item completing this cycle.
    assign rmax = (first_item || (item_new > max_q)) ? item_new : max_q;
    assign rmin = (first_item || (item_new < min_q)) ? item_new : min_q;
    assign rsum = (first_item ? '0 : sum_q) + SW'(item_new);

    assign in_window  = (lo_eff < item_new) && (item_new < hi_eff);
    assign out_window = (item_new < lo_eff) || (item_new > hi_eff);

    assign round_fn = (fn_eff == FN_MAX)  || (fn_eff == FN_MIN) ||
                      (fn_eff == FN_AVG)  || (fn_eff == FN_PMAX) ||
                      (fn_eff == FN_PMIN);

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        item_cnt_d = item_cnt_q;
        item_d     = item_q;
        fn_d       = fn_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        max_d      = max_q;
        min_d      = min_q;
        sum_d      = sum_q;
        peak_d     = peak_q;
        peak_set_d = peak_set_q;
        valid_d    = 1'b0;
        out_d      = out_q;

        if (accept) begin
            item_d = item_new;
            if (item_done) begin
                beat_cnt_d = '0;
                item_cnt_d = last_item ? '0 : item_cnt_q + ICW'(1);
                max_d      = rmax;
                min_d      = rmin;
                sum_d      = rsum;
            end else begin
                beat_cnt_d = beat_cnt_q + BCW'(1);
            end
        end

        if (round_start) begin
            fn_d = fn_sel;
            lo_d = thr_lo;
            hi_d = thr_hi;
            // A peak only carries across consecutive rounds of the same
            // peak function.
            if ((fn_sel != fn_q) || !((fn_sel == FN_PMAX) || (fn_sel == FN_PMIN))) begin
                peak_set_d = 1'b0;
            end
        end

        if (item_done) begin
            case (fn_eff)
                FN_EXT: begin
                    if (in_window) begin
                        valid_d = 1'b1;
                        out_d   = item_new;
                    end
                end
                FN_EXC: begin
                    if (out_window) begin
                        valid_d = 1'b1;
                        out_d   = item_new;
                    end
                end
                FN_MAX: begin
                    if (round_done) begin
                        valid_d = 1'b1;
                        out_d   = rmax;
                    end
                end
                FN_MIN: begin
                    if (round_done) begin
                        valid_d = 1'b1;
                        out_d   = rmin;
                    end
                end
                FN_AVG: begin
                    if (round_done) begin
                        valid_d = 1'b1;
                        out_d   = DW'(rsum >> LOG2R);
                    end
                end
                FN_PMAX: begin
                    if (round_done && (!peak_set_q || (rmax > peak_q))) begin
                        valid_d    = 1'b1;
                        out_d      = rmax;
                        peak_d     = rmax;
                        peak_set_d = 1'b1;
                    end
                end
                FN_PMIN: begin
                    if (round_done && (!peak_set_q || (rmin < peak_q))) begin
                        valid_d    = 1'b1;
                        out_d      = rmin;
                        peak_d     = rmin;
                        peak_set_d = 1'b1;
                    end
                end
                default: begin
                    // FN_NONE: data consumed, nothing produced.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. Only round-reducing functions pass through EVAL;
    // EXT/EXC/none rounds stay in FILL so busy never rises for them.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_FILL;
            S_FILL: if (round_done && round_fn) state_d = S_EVAL;
            S_EVAL: state_d = S_FILL;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == S_EVAL);
    end

    assign valid   = valid_q;
    assign iot_out = out_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            item_cnt_q <= '0;
            item_q     <= '0;
            fn_q       <= FN_NONE;
            lo_q       <= '0;
            hi_q       <= '0;
            max_q      <= '0;
            min_q      <= '0;
            sum_q      <= '0;
            peak_q     <= '0;
            peak_set_q <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            item_cnt_q <= item_cnt_d;
            item_q     <= item_d;
            fn_q       <= fn_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            max_q      <= max_d;
            min_q      <= min_d;
            sum_q      <= sum_d;
            peak_q     <= peak_d;
            peak_set_q <= peak_set_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_iotdf_param.sv
// -----------------------------------------------------------------------------
// tb_iotdf_param : self-checking bench for iotdf_param (default parameters)
// Directed and randomized rounds; expected results come from a round-level
// reference model (plain max/min/division/window tests over the item array).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iotdf_param;

    localparam int IN_W      = 8;
    localparam int N_BYTES   = 16;
    localparam int ROUND_LEN = 8;
    localparam int DW        = IN_W * N_BYTES;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          in_en  = 1'b0;
    logic [7:0]    iot_in = '0;
    logic [2:0]    fn_sel = '0;
    logic [DW-1:0] thr_lo = '0;
    logic [DW-1:0] thr_hi = '0;
    logic          busy;
    logic          valid;
    logic [DW-1:0] iot_out;

    iotdf_param #(
        .IN_W(IN_W),
        .N_BYTES(N_BYTES),
        .ROUND_LEN(ROUND_LEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_en(in_en),
        .iot_in(iot_in),
        .fn_sel(fn_sel),
        .thr_lo(thr_lo),
        .thr_hi(thr_hi),
        .busy(busy),
        .valid(valid),
        .iot_out(iot_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] got_q[$];
    logic          gotb_q[$];
    logic [DW-1:0] exp_q[$];
    logic          expb_q[$];
    int            busy_cyc = 0;

    logic [DW-1:0] itm[ROUND_LEN];

    // reference model state
    logic [2:0]    m_prevfn = '0;
    logic          m_pset   = 1'b0;
    logic [DW-1:0] m_peak   = '0;

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            got_q.push_back(iot_out);
            gotb_q.push_back(busy);
        end
        if (busy === 1'b1) busy_cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_q();
        got_q.delete(); gotb_q.delete(); exp_q.delete(); expb_q.delete();
    endtask

    task automatic m_reset();
        m_prevfn = '0; m_pset = 1'b0; m_peak = '0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Reference model: what one complete round should produce.
    task automatic model_round(input logic [2:0] fn, input logic [DW-1:0] lo, input logic [DW-1:0] hi);
        logic [DW-1:0] mx, mn;
        logic [DW+2:0] s;
        if (fn != m_prevfn || (fn != 3'd6 && fn != 3'd7)) m_pset = 1'b0;
        m_prevfn = fn;
        mx = itm[0]; mn = itm[0]; s = '0;
        for (int i = 0; i < ROUND_LEN; i++) begin
            if (itm[i] > mx) mx = itm[i];
            if (itm[i] < mn) mn = itm[i];
            s = s + {3'b000, itm[i]};
        end
        case (fn)
            3'd1: begin exp_q.push_back(mx); expb_q.push_back(1'b1); end
            3'd2: begin exp_q.push_back(mn); expb_q.push_back(1'b1); end
            3'd3: begin exp_q.push_back(DW'(s / ROUND_LEN)); expb_q.push_back(1'b1); end
            3'd4: for (int i = 0; i < ROUND_LEN; i++)
                      if (lo < itm[i] && itm[i] < hi) begin exp_q.push_back(itm[i]); expb_q.push_back(1'b0); end
            3'd5: for (int i = 0; i < ROUND_LEN; i++)
                      if (itm[i] < lo || itm[i] > hi) begin exp_q.push_back(itm[i]); expb_q.push_back(1'b0); end
            3'd6: if (!m_pset || mx > m_peak) begin
                      exp_q.push_back(mx); expb_q.push_back(1'b1); m_peak = mx; m_pset = 1'b1;
                  end
            3'd7: if (!m_pset || mn < m_peak) begin
                      exp_q.push_back(mn); expb_q.push_back(1'b1); m_peak = mn; m_pset = 1'b1;
                  end
            default: ;
        endcase
    endtask

    // Drive one beat honouring busy; called and returns at posedge+1.
    task automatic send_beat(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) begin @(posedge clk); #1; end
        guard = 0;
        while (busy !== 1'b0 && guard < 50) begin @(posedge clk); #1; guard++; end
        if (guard >= 50) begin
            checks++; errors++;
            $display("FAIL busy_timeout busy=%b required 0 within 50 cycles", busy);
        end
        in_en = 1'b1; iot_in = b;
        @(posedge clk); #1;
        in_en = 1'b0;
    endtask

    // gapmode: 0 none, 1 three-cycle gaps inside items, 2 random gaps
    task automatic run_round(input logic [2:0] fn, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                             input int gapmode, input int chg_at, input logic [2:0] chg_fn);
        int n, g;
        n = 0;
        fn_sel = fn; thr_lo = lo; thr_hi = hi;
        for (int i = 0; i < ROUND_LEN; i++) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (n == chg_at) begin fn_sel = chg_fn; thr_lo = ~lo; thr_hi = ~hi; end
                if (gapmode == 1) g = (b % 5 == 2) ? 3 : 0;
                else if (gapmode == 2) g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                else g = 0;
                send_beat(itm[i][DW-1-IN_W*b -: IN_W], g);
                n++;
            end
        end
        model_round(fn, lo, hi);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_en = 1'b1; iot_in = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        in_en = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || iot_out !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b valid=%b out=%h required 0/0/0", busy, valid, iot_out);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b valid=%b required 0/0", busy, valid);
        end
        m_reset();
    endtask

    task automatic test_max();
        logic [7:0] bb;
        clear_q();
        for (int i = 0; i < ROUND_LEN; i++) begin bb = 8'h10 + 8'(i); itm[i] = {16{bb}}; end
        run_round(3'd1, '0, '0, 0, -1, 3'd0);
        checks++;
        if (valid !== 1'b1 || busy !== 1'b1 || iot_out !== {16{8'h17}}) begin
            errors++;
            $display("FAIL max_timing valid=%b busy=%b out=%h required 1/1/%h", valid, busy, iot_out, {16{8'h17}});
        end
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL max_strobe_width valid=%b busy=%b required 0/0", valid, busy);
        end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL max_count got=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k] || gotb_q[k] !== expb_q[k]) begin
                errors++; $display("FAIL max_val[%0d] got=%h busy=%b required %h busy=%b", k, got_q[k], gotb_q[k], exp_q[k], expb_q[k]);
            end
        end
    endtask

    task automatic test_avg();
        clear_q();
        for (int i = 0; i < ROUND_LEN; i++) itm[i] = DW'(i + 1);
        run_round(3'd3, '0, '0, 0, -1, 3'd0);
        for (int i = 0; i < ROUND_LEN; i++) itm[i] = '1;
        run_round(3'd3, '0, '0, 0, -1, 3'd0);
        settle();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== DW'(4) || got_q[1] !== {DW{1'b1}}) begin
            errors++; $display("FAIL avg_const count=%0d required 2 values 4 and all-ones", got_q.size());
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL avg_count got=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k] || gotb_q[k] !== expb_q[k]) begin
                errors++; $display("FAIL avg_val[%0d] got=%h busy=%b required %h busy=%b", k, got_q[k], gotb_q[k], exp_q[k], expb_q[k]);
            end
        end
    endtask

    task automatic test_ext_exc();
        logic [DW-1:0] lo, hi, a, b;
        lo = {8'h6F, {120{1'b1}}};
        hi = {8'hAF, {120{1'b1}}};
        a  = {8'h80, 120'b0};
        b  = {8'hB0, 120'b0};
        itm[0] = a; itm[1] = lo; itm[2] = b;
        for (int i = 3; i < ROUND_LEN; i++) itm[i] = hi;
        for (int f = 4; f <= 5; f++) begin
            clear_q();
            run_round(3'(f), lo, hi, 0, -1, 3'd0);
            settle();
            checks++;
            if (got_q.size() != 1 || got_q[0] !== ((f == 4) ? a : b)) begin
                errors++; $display("FAIL ext_exc_const fn=%0d count=%0d required exactly one item %h", f, got_q.size(), (f == 4) ? a : b);
            end
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL ext_exc_count fn=%0d got=%0d required %0d", f, got_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                checks++;
                if (got_q[k] !== exp_q[k] || gotb_q[k] !== expb_q[k]) begin
                    errors++; $display("FAIL ext_exc_val[%0d] got=%h busy=%b required %h busy=%b", k, got_q[k], gotb_q[k], exp_q[k], expb_q[k]);
                end
            end
        end
    endtask

    task automatic test_pmax();
        logic [7:0] maxes[4];
        int b0;
        maxes = '{8'h50, 8'h40, 8'h60, 8'h60};
        clear_q();
        b0 = busy_cyc;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < ROUND_LEN; i++) itm[i] = (i == 3) ? {16{maxes[r]}} : {16{8'h01 + 8'(i)}};
            run_round(3'd6, '0, '0, 0, -1, 3'd0);
        end
        for (int i = 0; i < ROUND_LEN; i++) itm[i] = {16{8'h70 + 8'(i)}};
        run_round(3'd7, '0, '0, 0, -1, 3'd0);
        settle();
        checks++;
        if (got_q.size() != 3 || got_q[0] !== {16{8'h50}} || got_q[1] !== {16{8'h60}} || got_q[2] !== {16{8'h70}}) begin
            errors++; $display("FAIL pmax_const count=%0d required 3 outputs 50.. 60.. 70..", got_q.size());
        end
        checks++;
        if (busy_cyc - b0 != 5) begin
            errors++; $display("FAIL pmax_busy_cycles got=%0d required 5", busy_cyc - b0);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL pmax_count got=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k] || gotb_q[k] !== expb_q[k]) begin
                errors++; $display("FAIL pmax_val[%0d] got=%h busy=%b required %h busy=%b", k, got_q[k], gotb_q[k], exp_q[k], expb_q[k]);
            end
        end
    endtask

    task automatic test_gaps();
        clear_q();
        for (int i = 0; i < ROUND_LEN; i++) itm[i] = rnd128();
        run_round(3'd3, '0, '0, 0, -1, 3'd0);
        run_round(3'd3, '0, '0, 1, -1, 3'd0);
        run_round(3'd2, '0, '0, 1, -1, 3'd0);
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL gaps_count got=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k] || gotb_q[k] !== expb_q[k]) begin
                errors++; $display("FAIL gaps_val[%0d] got=%h busy=%b required %h busy=%b", k, got_q[k], gotb_q[k], exp_q[k], expb_q[k]);
            end
        end
    endtask

    task automatic test_busy_drop();
        clear_q();
        for (int i = 0; i < ROUND_LEN; i++) itm[i] = rnd128();
        run_round(3'd1, '0, '0, 0, -1, 3'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL drop_busy busy=%b required 1", busy);
        end
        // stray beat while busy: must be ignored
        in_en = 1'b1; iot_in = 8'hFF;
        @(posedge clk); #1;
        in_en = 1'b0;
        for (int i = 0; i < ROUND_LEN; i++) itm[i] = rnd128();
        run_round(3'd3, '0, '0, 0, -1, 3'd0);
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL drop_count got=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k] || gotb_q[k] !== expb_q[k]) begin
                errors++; $display("FAIL drop_val[%0d] got=%h busy=%b required %h busy=%b", k, got_q[k], gotb_q[k], exp_q[k], expb_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        fn_sel = 3'd1;
        for (int n = 0; n < 70; n++) send_beat(8'($urandom_range(0, 255)), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || iot_out !== '0) begin
            errors++; $display("FAIL midreset_state busy=%b valid=%b out=%h required 0/0/0", busy, valid, iot_out);
        end
        settle();
        for (int i = 0; i < ROUND_LEN; i++) itm[i] = rnd128();
        run_round(3'd1, '0, '0, 0, -1, 3'd0);
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midreset_count got=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k] || gotb_q[k] !== expb_q[k]) begin
                errors++; $display("FAIL midreset_val[%0d] got=%h busy=%b required %h busy=%b", k, got_q[k], gotb_q[k], exp_q[k], expb_q[k]);
            end
        end
    endtask

    task automatic test_latch();
        clear_q();
        for (int i = 0; i < ROUND_LEN; i++) itm[i] = rnd128();
        run_round(3'd1, '0, '0, 0, 40, 3'd2);
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL latch_count got=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k] || gotb_q[k] !== expb_q[k]) begin
                errors++; $display("FAIL latch_val[%0d] got=%h busy=%b required %h busy=%b", k, got_q[k], gotb_q[k], exp_q[k], expb_q[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]    fn;
        logic [DW-1:0] lo, hi, t;
        int            r;
        clear_q();
        fn = 3'd0;
        for (int rd = 0; rd < 14; rd++) begin
            if (rd == 0 || $urandom_range(0, 2) != 0) fn = 3'($urandom_range(0, 7));
            lo = rnd128(); hi = rnd128();
            if (lo > hi) begin t = lo; lo = hi; hi = t; end
            for (int i = 0; i < ROUND_LEN; i++) begin
                r = int'($urandom_range(0, 5));
                itm[i] = (r == 0) ? lo : (r == 1) ? hi : rnd128();
            end
            run_round(fn, lo, hi, 2, -1, 3'd0);
        end
        settle();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count got=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k] || gotb_q[k] !== expb_q[k]) begin
                errors++; $display("FAIL random_val[%0d] got=%h busy=%b required %h busy=%b", k, got_q[k], gotb_q[k], exp_q[k], expb_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_avg();
        test_ext_exc();
        test_pmax();
        test_gaps();
        test_busy_drop();
        test_reset_mid();
        test_latch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
